disp_scan_sched: RTL and testbench

//  Scan scheduler for the 4-digit multiplexed 7-segment display. Owns digit sequencing,

---
 rtl/disp_scan_sched.sv | 205 ++++++++++++++++++++
 tb/tb_disp_scan_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_sched
// Purpose  : Scan scheduler for a 4-digit multiplexed 7-segment display.
//            Sequences digits 3,2,1,0, blanks all anodes at the start of
//            every digit slot (anti-ghosting), decodes BCD to segments,
//            optionally suppresses leading zeros and offers the upstream
//            datapath a level load / pulse ack handshake that only takes
//            effect at frame boundaries.
// Ports    : clk        in   system clock
//            rst        in   synchronous reset, active-high
//            bcd_in     in   [15:0] four BCD digits, [15:12] = thousands
//            dp_in      in   [3:0] decimal points, active-high, bit3 = thousands
//            lz_en      in   leading-zero suppression enable (used live)
//            load       in   level request to latch bcd_in/dp_in at boundary
//            bright     in   [2:0] brightness (only with DISP_PWM_EN)
//            load_ack   out  1-cycle pulse, inputs copied to active regs
//            frame_done out  1-cycle pulse at each frame boundary
//            seg_n      out  [7:0] {a,b,c,d,e,f,g,dp}, active-low, registered
//            an_n       out  [3:0] digit anodes, active-low, registered
// Config   : define DISP_PWM_EN to add the bright port and slice-based
//            anode dimming inside the SHOW window.
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan_sched #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 300,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    input  logic        load,
`ifdef DISP_PWM_EN
    input  logic [2:0]  bright,
`endif
    output logic        load_ack,
    output logic        frame_done,
    output logic [7:0]  seg_n,
    output logic [3:0]  an_n
);

    // Clocks per digit slot.
    localparam int c_T  = CLK_HZ / SCAN_HZ;
    // Counter width: holds 0..c_T-1 (both prescaler and blank/show count).
    localparam int c_CW = (c_T > 1) ? $clog2(c_T) : 1;

    localparam logic [0:0] c_ST_BLANK = 1'b0;
    localparam logic [0:0] c_ST_SHOW  = 1'b1;

    generate
        if (BLANK_CYC >= c_T) begin : g_blank_check
            $error("disp_scan_sched: BLANK_CYC must be smaller than CLK_HZ/SCAN_HZ");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_CW-1:0] r_presc;
    logic [c_CW-1:0] r_cnt;      // blank count in BLANK, slot offset in SHOW
    logic [0:0]      r_state;
    logic [1:0]      r_idx;
    logic [15:0]     r_active;
    logic [3:0]      r_dp;
    logic [7:0]      r_seg_n;
    logic [3:0]      r_an_n;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic            w_tick;
    logic            w_boundary;
    logic            w_latch;
    logic            w_blank_done;
    logic            w_enter_show;
    logic [c_CW-1:0] w_presc_nxt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic [0:0]      w_state_nxt;
    logic [1:0]      w_idx_nxt;
    logic [3:0]      w_digit;
    logic [3:0]      w_lead;
    logic [7:0]      w_seg;
    logic            w_pwm_on;
    logic            w_drive;
    logic [7:0]      w_seg_n_nxt;
    logic [3:0]      w_an_n_nxt;

    function automatic logic [7:0] f_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = 8'hFD;   // non-BCD shown as a dash
        endcase
        return s;
    endfunction

    assign w_tick       = (r_presc == c_CW'(c_T - 1));
    assign w_boundary   = w_tick && (r_idx == 2'd0);
    // Gating with rst drops a load that coincides with reset.
    assign w_latch      = w_boundary && load && !rst;
    assign w_blank_done = ((int'(r_cnt) + 1) >= BLANK_CYC);
    assign w_enter_show = !w_tick && (r_state == c_ST_BLANK) && w_blank_done;

    assign load_ack   = w_latch;
    assign frame_done = w_boundary && !rst;

    always_comb begin
        w_presc_nxt = w_tick ? '0 : r_presc + c_CW'(1);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CW'(1);
        w_idx_nxt   = r_idx;
        if (w_tick) begin
            // Slot end: from SHOW (or, defensively, from BLANK) start the
            // next digit's blanking; idx wraps 0 -> 3 by modular decrement.
            w_state_nxt = c_ST_BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx - 2'd1;
        end else if (w_enter_show) begin
            w_state_nxt = c_ST_SHOW;
            w_cnt_nxt   = '0;
        end
    end

    // Digit k is a leading zero when it and every higher digit are zero.
    assign w_lead[3] = (r_active[15:12] == 4'd0);
    assign w_lead[2] = w_lead[3] && (r_active[11:8] == 4'd0);
    assign w_lead[1] = w_lead[2] && (r_active[7:4] == 4'd0);
    assign w_lead[0] = 1'b0;

    assign w_digit = r_active[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_seg = f_decode(w_digit);
        if (lz_en && w_lead[r_idx]) begin
            w_seg = 8'hFF;
        end
        if (r_dp[r_idx]) begin
            w_seg[0] = 1'b0;
        end
    end

`ifdef DISP_PWM_EN
    // SHOW window split into 8 slices; anode on for slices 0..bright.
    localparam int c_S = (c_T - BLANK_CYC) / 8;
    logic [2:0] r_bright;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bright <= 3'd0;
        end else if (w_enter_show) begin
            r_bright <= bright;
        end
    end

    assign w_pwm_on = (r_bright == 3'd7) ||
                      (int'(r_cnt) < ((int'(r_bright) + 1) * c_S));
`else
    assign w_pwm_on = 1'b1;
`endif

    assign w_drive     = (r_state == c_ST_SHOW) && w_pwm_on;
    assign w_seg_n_nxt = w_drive ? w_seg : 8'hFF;
    assign w_an_n_nxt  = w_drive ? ~(4'b0001 << r_idx) : 4'hF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc  <= '0;
            r_cnt    <= '0;
            r_state  <= c_ST_BLANK;
            r_idx    <= 2'd3;
            r_active <= 16'h0000;
            r_dp     <= 4'h0;
            r_seg_n  <= 8'hFF;
            r_an_n   <= 4'hF;
        end else begin
            r_presc  <= w_presc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_seg_n  <= w_seg_n_nxt;
            r_an_n   <= w_an_n_nxt;
            if (w_latch) begin
                r_active <= bcd_in;
                r_dp     <= dp_in;
            end
        end
    end

    assign seg_n = r_seg_n;
    assign an_n  = r_an_n;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan_sched
// Purpose  : Self-checking bench for disp_scan_sched (T=10, BLANK_CYC=2).
//            A cycle-count based model predicts every output each cycle;
//            directed phases pin the model with literal values, followed by
//            randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan_sched;

    logic        clk;
    logic        rst;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic        load;
    logic [2:0]  bright;
    logic        load_ack;
    logic        frame_done;
    logic [7:0]  seg_n;
    logic [3:0]  an_n;

    int total;
    int bad;

    disp_scan_sched #(
        .CLK_HZ    (1000),
        .SCAN_HZ   (100),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .load       (load),
`ifdef DISP_PWM_EN
        .bright     (bright),
`endif
        .load_ack   (load_ack),
        .frame_done (frame_done),
        .seg_n      (seg_n),
        .an_n       (an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: position in the scan follows from cycles since reset
    // ------------------------------------------------------------------
    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 8'h03;
            4'd1: return 8'h9F;
            4'd2: return 8'h25;
            4'd3: return 8'h0D;
            4'd4: return 8'h99;
            4'd5: return 8'h49;
            4'd6: return 8'h41;
            4'd7: return 8'h1F;
            4'd8: return 8'h01;
            4'd9: return 8'h09;
            default: return 8'hFD;
        endcase
    endfunction

    int          m_n;
    int          m_off;
    int          m_idx;
    bit          m_valid;
    bit          m_bnd;
    logic [15:0] m_act;
    logic [15:0] m_sh;
    logic [3:0]  m_dp;
    logic [7:0]  m_s;
    logic [7:0]  e_seg;
    logic [3:0]  e_an;

    initial m_valid = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (m_valid) begin
                chk("fd_in_rst", {31'd0, frame_done}, 32'd0);
                chk("ack_in_rst", {31'd0, load_ack}, 32'd0);
            end
            m_n     = 0;
            m_act   = 16'h0000;
            m_dp    = 4'h0;
            e_seg   = 8'hFF;
            e_an    = 4'hF;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_off = m_n % 10;
            m_idx = 3 - ((m_n / 10) % 4);
            m_bnd = (m_off == 9) && (m_idx == 0);
            chk("seg_n", {24'd0, seg_n}, {24'd0, e_seg});
            chk("an_n", {28'd0, an_n}, {28'd0, e_an});
            chk("frame_done", {31'd0, frame_done}, {31'd0, m_bnd});
            chk("load_ack", {31'd0, load_ack}, {31'd0, (m_bnd && load)});
            if (m_off >= 2) begin
                m_sh = m_act >> (4 * m_idx);
                if (lz_en && (m_idx != 0) && (m_sh == 16'd0)) m_s = 8'hFF;
                else m_s = seg_of(m_sh[3:0]);
                if (m_dp[m_idx]) m_s[0] = 1'b0;
                e_seg = m_s;
                e_an  = ~(4'b0001 << m_idx);
            end else begin
                e_seg = 8'hFF;
                e_an  = 4'hF;
            end
            if (m_bnd && load) begin
                m_act = bcd_in;
                m_dp  = dp_in;
            end
            m_n++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Returns at the negedge of the cycle in which load_ack is seen.
    task automatic wait_ack();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (load_ack) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ack_seen", {31'd0, ok}, 32'd1);
        chk("ack_on_boundary", {31'd0, frame_done}, 32'd1);
    endtask

    task automatic drop_load();
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acks;
        int per;
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        bcd_in = 16'h0000;
        dp_in  = 4'h0;
        lz_en  = 1'b0;
        load   = 1'b0;
        bright = 3'd7;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;                    // now in cycle 0

        // Reset release and scan order
        step(1);  chk("c0_an", {28'd0, an_n}, 32'hF);
                  chk("c0_seg", {24'd0, seg_n}, 32'hFF);
        step(2);  chk("c2_an", {28'd0, an_n}, 32'hF);
        step(1);  chk("c3_an", {28'd0, an_n}, 32'b0111);
                  chk("c3_seg", {24'd0, seg_n}, 32'h03);
        step(10); chk("c13_an", {28'd0, an_n}, 32'b1011);

        // Load mid-frame: display unchanged until boundary
        @(posedge clk);
        #1 load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0100;   // cycle 14
        step(10); chk("c23_an", {28'd0, an_n}, 32'b1101);
                  chk("c23_seg_old", {24'd0, seg_n}, 32'h03);
        wait_ack();
        drop_load();
        step(4);  chk("d3_1234", {24'd0, seg_n}, 32'h9F);
                  chk("d3_an", {28'd0, an_n}, 32'b0111);
        step(10); chk("d2_1234_dp", {24'd0, seg_n}, 32'h24);
        step(10); chk("d1_1234", {24'd0, seg_n}, 32'h0D);
        step(10); chk("d0_1234", {24'd0, seg_n}, 32'h99);

        // Leading-zero suppression
        @(posedge clk);
        #1 load = 1'b1; bcd_in = 16'h0050; dp_in = 4'h0; lz_en = 1'b1;
        wait_ack();
        drop_load();
        step(4);  chk("lz_d3", {24'd0, seg_n}, 32'hFF);
        step(10); chk("lz_d2", {24'd0, seg_n}, 32'hFF);
        step(10); chk("lz_d1", {24'd0, seg_n}, 32'h49);
        step(10); chk("lz_d0", {24'd0, seg_n}, 32'h03);
        @(posedge clk);
        #1 lz_en = 1'b0;
        step(10); chk("nolz_d3", {24'd0, seg_n}, 32'h03);
                  chk("nolz_d3_an", {28'd0, an_n}, 32'b0111);
        step(10); chk("nolz_d2", {24'd0, seg_n}, 32'h03);

        // Dash and frame period
        @(posedge clk);
        #1 load = 1'b1; bcd_in = 16'h00A0;
        wait_ack();
        drop_load();
        step(24); chk("dash_d1", {24'd0, seg_n}, 32'hFD);
        per = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            per = i;
            if (frame_done) break;
        end
        chk("fd_period", per, 32'd40);   // now at a boundary (idx 0)

        // Reset during idx 1 with a load pending
        @(posedge clk);
        #1 load = 1'b1; bcd_in = 16'h9876;      // boundary+1
        step(24);                               // boundary+24, idx 1 shown
        chk("pre_rst_an", {28'd0, an_n}, 32'b1101);
        @(posedge clk);
        #1 rst = 1'b1; load = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;                          // cycle 0 after reset
        acks = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (load_ack) acks++;
            if (i == 0) begin
                chk("rst_seg", {24'd0, seg_n}, 32'hFF);
                chk("rst_an", {28'd0, an_n}, 32'hF);
            end
            if (i == 3) chk("rst_idx3", {28'd0, an_n}, 32'b0111);
        end
        chk("rst_no_ack", acks, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            load = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 9) < 5) bcd_in[4*k +: 4] = 4'd0;
                    else bcd_in[4*k +: 4] = 4'($urandom_range(0, 15));
                end
                dp_in = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
            rst = ($urandom_range(0, 599) == 0);
        end
        @(posedge clk);
        #1 rst = 1'b0; load = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
